fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Front-end producer for the instruction queue.
- Holds the fetch PC and issues one SUPERSCALAR-wide read per fetch group to instruction memory.
- Buffers the returned group and pushes it into the queue with its starting commit order, respecting the queue's full flag.
- Accepts redirects from the back end (mispredict/flush) at any time and discards stale in-flight data.

Parameters:
SUPERSCALAR, 1, instructions per fetch group and per queue line
RESET_PC, 32'h1eceb000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
imem_req  out  1  single-cycle read request pulse
imem_addr  out  32  byte address of first word in group; valid while imem_req=1
imem_resp  in  1  read data valid, exactly one per request, at least 1 cycle after imem_req
imem_rdata  in  SUPERSCALAR*32  group data; word i at bits [i*32+:32] = mem[imem_addr+4i]
instr_full  in  1  queue has no free line
instr_push  out  1  push one line into queue this cycle
instr_in  out  SUPERSCALAR*32  line data, same packing as imem_rdata
order_in  out  64  commit order of word 0 of the pushed line
redirect_valid  in  1  redirect fetch this cycle
redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced to 0
redirect_order  in  64  order number of the instruction at redirect_pc

Behaviour:
- Registers: pc[31:0], order[63:0], buf[SUPERSCALAR*32-1:0], state.
- pc and order wrap modulo 2^32 and 2^64.
- Reset (async):
  - state=IDLE, pc=RESET_PC, order=0, buf=0.
  - imem_req=0 and instr_push=0 whenever rst=1 or state=IDLE.
- Combinational outputs:
  - imem_req = (state==REQ) && !redirect_valid
  - imem_addr = pc
  - instr_push = (state==HOLD) && !instr_full && !redirect_valid
  - instr_in = buf
  - order_in = order
- Redirect (any state except IDLE):
  - pc<=redirect_pc&~3 and order<=redirect_order.
  - Redirect takes priority over push and request in the same cycle.
- State transitions:
  - IDLE -> REQ unconditionally. First imem_req occurs 1 cycle after rst deasserts.
  - REQ, redirect: stay REQ; no request is issued that cycle.
  - REQ, otherwise: request issued, -> WAIT.
  - WAIT, imem_resp with no redirect: buf<=imem_rdata, -> HOLD.
  - WAIT, imem_resp with redirect: data discarded, -> REQ.
  - WAIT, redirect without imem_resp: -> DROP; one response is still owed.
  - DROP, imem_resp: data discarded, -> REQ. A redirect in the same cycle only updates pc/order.
  - DROP, redirect without imem_resp: stay DROP; pc/order updated.
  - HOLD, redirect: buf dropped, -> REQ.
  - HOLD, instr_full=1: stay HOLD; buf and order held stable indefinitely.
  - HOLD, push (instr_full=0): pc<=pc+4*SUPERSCALAR, order<=order+SUPERSCALAR, -> REQ.
- Latency:
  - Response at cycle k: push at k+1 (queue not full), next request at k+2.
  - Peak rate is one group per 3 cycles with 1-cycle memory.
- At most one outstanding memory request at any time. imem_resp in REQ, HOLD or IDLE is a protocol error; the bench asserts it never occurs.
- No alignment of pc to the group size: pc advances by 4*SUPERSCALAR from whatever word address was loaded.
- Reset mid-operation (any state, including WAIT/DROP):
  - Returns to IDLE immediately. The external memory is reset by the same rst.
  - No response from a pre-reset request is consumed.

Decomposition:
- Shared package (front-end types package) holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, DROP, HOLD}
  - constant FETCH_BYTES = 4*SUPERSCALAR
- No sub-module; FSM, PC/order counters and the line buffer stay inline in one module.

Test Plan:
- Reset release, memory latency 1, queue never full, SUPERSCALAR=2:
  - imem_req cycle 1, addr 0x1eceb000; resp cycle 2.
  - Push cycle 3 with order_in=0, instr_in=mem words.
  - Next req cycle 4, addr 0x1eceb008; second push order_in=2.
- Queue full for 5 cycles while in HOLD:
  - instr_push=0 throughout; instr_in/order_in stable.
  - Push on first cycle instr_full=0; no new imem_req until after the push.
- Redirect to 0x1ecec102, order 0x40, while in WAIT (latency 4):
  - Stale resp discarded with no push.
  - Next imem_addr=0x1ecec100; the following push has order_in=0x40.
- Redirect coincident with imem_resp in WAIT, and coincident with a would-be push in HOLD:
  - No push in either case.
  - Next request uses the redirect PC.
- pc=0xfffffffc, order=64'hffff_ffff_ffff_ffff, SUPERSCALAR=1, push:
  - pc wraps to 0x00000000, order wraps to 0.
- Assert rst during DROP, then release:
  - Outputs 0 during reset.
  - First request at RESET_PC with order 0; the late response before the first new request is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared front-end types: fetch FSM state encoding and fetch-group sizing.
package fetch_unit_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,  // one-cycle settle after reset
        REQ  = 3'd1,  // ready to issue a group read
        WAIT = 3'd2,  // read outstanding, data wanted
        DROP = 3'd3,  // read outstanding, data stale (redirected)
        HOLD = 3'd4   // group buffered, waiting to push into the queue
    } fetch_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Byte stride of one fetch group (FETCH_BYTES = 4*SUPERSCALAR).
    function automatic int unsigned fetch_bytes(input int unsigned superscalar);
        return WORD_BYTES * superscalar;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch unit: holds the fetch PC, issues one group read at a time to
// instruction memory, buffers the returned group and pushes it into the
// instruction queue tagged with its commit order. Redirects may arrive in
// any state; data from a read issued before a redirect is discarded.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned SUPERSCALAR = 1,
    parameter logic [31:0] RESET_PC    = 32'h1eceb000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic                      imem_resp,
    input  logic [SUPERSCALAR*32-1:0] imem_rdata,
    input  logic                      instr_full,
    output logic                      instr_push,
    output logic [SUPERSCALAR*32-1:0] instr_in,
    output logic [63:0]               order_in,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic [63:0]               redirect_order
);

    localparam int unsigned LINE_W      = SUPERSCALAR * 32;
    localparam logic [31:0] FETCH_BYTES = 32'(fetch_bytes(SUPERSCALAR));
    localparam logic [63:0] GROUP_WORDS = 64'(SUPERSCALAR);

    fetch_state_t      r_state;
    logic [31:0]       r_pc;
    logic [63:0]       r_order;
    logic [LINE_W-1:0] r_buf;

    logic [31:0]       w_redirect_pc;
    logic              w_redirect;

    // Redirect targets are word aligned; low address bits are dropped.
    assign w_redirect_pc = redirect_pc & ~32'd3;
    // IDLE ignores redirects: the PC is still settling out of reset.
    assign w_redirect    = redirect_valid && (r_state != IDLE);

    // A redirect suppresses both the request and the push of its cycle.
    assign imem_req   = (r_state == REQ)  && !redirect_valid;
    assign imem_addr  = r_pc;
    assign instr_push = (r_state == HOLD) && !instr_full && !redirect_valid;
    assign instr_in   = r_buf;
    assign order_in   = r_order;

    // PC/order: redirect wins over the post-push advance; both wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_order <= 64'd0;
        end else if (w_redirect) begin
            r_pc    <= w_redirect_pc;
            r_order <= redirect_order;
        end else if (instr_push) begin
            r_pc    <= r_pc + FETCH_BYTES;
            r_order <= r_order + GROUP_WORDS;
        end
    end

    // Fetch sequencer and group buffer; at most one read is ever outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_buf   <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (!redirect_valid) r_state <= WAIT;
                end
                WAIT: begin
                    if (imem_resp) begin
                        if (redirect_valid) begin
                            r_state <= REQ;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        // The owed response must still be absorbed.
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_resp) r_state <= REQ;
                end
                HOLD: begin
                    // Buffer stays stable while the queue is full.
                    if (redirect_valid || !instr_full) r_state <= REQ;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
